factor_fetch_arbiter: RTL and testbench

//  Upstream factor-matrix fetch stage for the ComputePE array. It collects per-PE row-address

---
 rtl/factor_fetch_arbiter.sv | 170 +++++++++++++++++
 tb/tb_factor_fetch_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/factor_fetch_arbiter.sv
// Factor-matrix fetch stage: round-robin arbitration of per-PE row requests, in-order memory
// reads for the granted PE, and a one-cycle broadcast of the gathered rows tagged with its id.
module factor_fetch_arbiter #(
    parameter int NUM_COMPUTE_UNITS      = 8,
    parameter int TENSOR_DIMENSIONS      = 3,
    parameter int RANK_FACTOR_MATRIX     = 16,
    parameter int FACTOR_MATRIX_WIDTH    = 32,
    parameter int MODE_TENSOR_ADDR_WIDTH = 16,
    localparam int N  = NUM_COMPUTE_UNITS,
    localparam int M  = TENSOR_DIMENSIONS - 1,
    localparam int A  = MODE_TENSOR_ADDR_WIDTH,
    localparam int RW = RANK_FACTOR_MATRIX * FACTOR_MATRIX_WIDTH,
    localparam int MW = $clog2(M) + 1,
    localparam int IW = (N > 1) ? $clog2(N) : 1,
    localparam int CW = $clog2(N) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*M-1:0]    req_en,
    input  logic [N*M*A-1:0]  req_addr,
    output logic [N-1:0]      req_ack,
    output logic              mem_rd_en,
    input  logic              mem_rd_ready,
    output logic [MW-1:0]     mem_rd_mode,
    output logic [A-1:0]      mem_rd_addr,
    input  logic              mem_rd_valid,
    input  logic [RW-1:0]     mem_rd_data,
    output logic [M-1:0]      resp_en,
    output logic [M*RW-1:0]   resp_data,
    output logic [CW-1:0]     resp_compute_id,
    output logic              proto_err,
    output logic [1:0]        dbg_state,
    output logic [IW-1:0]     dbg_rr_ptr
);

    // Read command handshake: a command transfers on a clock edge where mem_rd_en & mem_rd_ready;
    // while ready is low, en/mode/addr stay unchanged. mem_rd_valid has no back-pressure.
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t         state, state_nxt;
    logic [IW-1:0]  rr_ptr;
    logic [IW-1:0]  grant_id;
    logic [M-1:0]   mask;
    logic [M-1:0]   pend;
    logic [M-1:0]   ret_pend;
    logic [M*A-1:0] addr_q;
    logic [MW-1:0]  ret_cnt;
    logic [MW-1:0]  out_cnt;
    logic [N-1:0]   req_ack_q;
    logic [RW-1:0]  slots [M];

    logic           any_elig;
    logic [IW-1:0]  grant_nxt;
    logic [IW:0]    cand;
    logic [MW-1:0]  cur_mode;
    logic [MW-1:0]  ret_slot;
    logic [M-1:0]   cur_bit;
    logic [M-1:0]   ret_bit;
    logic           cmd_fire;
    logic           ret_fire;
    logic           issue_last;

    function automatic logic [MW-1:0] first_set(input logic [M-1:0] v);
        first_set = '0;
        for (int i = M - 1; i >= 0; i--) begin
            if (v[i]) first_set = MW'(i);
        end
    endfunction

    function automatic logic [MW-1:0] count_set(input logic [M-1:0] v);
        count_set = '0;
        for (int i = 0; i < M; i++) begin
            if (v[i]) count_set = count_set + MW'(1);
        end
    endfunction

    // Scan from rr_ptr upward, wrapping, and take the first PE with a non-zero mask.
    always_comb begin
        any_elig  = 1'b0;
        grant_nxt = '0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, rr_ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
            if (!any_elig && (|req_en[int'(cand)*M +: M])) begin
                any_elig  = 1'b1;
                grant_nxt = cand[IW-1:0];
            end
        end
    end

    assign cur_mode   = first_set(pend);
    assign ret_slot   = first_set(ret_pend);
    assign cur_bit    = M'(1) << cur_mode;
    assign ret_bit    = M'(1) << ret_slot;
    assign mem_rd_en  = (state == S_ISSUE) && (|pend);
    assign mem_rd_mode = mem_rd_en ? cur_mode : '0;
    assign mem_rd_addr = mem_rd_en ? addr_q[int'(cur_mode)*A +: A] : '0;
    assign cmd_fire   = mem_rd_en && mem_rd_ready;
    assign ret_fire   = mem_rd_valid && (out_cnt != '0);
    assign issue_last = ((pend & ~cur_bit) == '0);
    assign req_ack    = req_ack_q;
    assign dbg_state  = state;
    assign dbg_rr_ptr = rr_ptr;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (any_elig) state_nxt = S_ISSUE;
            S_ISSUE: if (cmd_fire && issue_last) state_nxt = S_WAIT;
            S_WAIT:  if (ret_cnt == count_set(mask)) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        resp_en         = '0;
        resp_data       = '0;
        resp_compute_id = '0;
        if (state == S_RESP) begin
            resp_en         = mask;
            resp_compute_id = CW'(grant_id);
            for (int m = 0; m < M; m++) resp_data[m*RW +: RW] = slots[m];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            mask      <= '0;
            pend      <= '0;
            ret_pend  <= '0;
            addr_q    <= '0;
            ret_cnt   <= '0;
            out_cnt   <= '0;
            req_ack_q <= '0;
            proto_err <= 1'b0;
            for (int m = 0; m < M; m++) slots[m] <= '0;
        end else begin
            state     <= state_nxt;
            req_ack_q <= '0;
            out_cnt   <= out_cnt + MW'(cmd_fire) - MW'(ret_fire);
            // A return with nothing outstanding is dropped and flagged until reset.
            if (mem_rd_valid && (out_cnt == '0)) proto_err <= 1'b1;
            if ((state == S_IDLE) && any_elig) begin
                grant_id  <= grant_nxt;
                mask      <= req_en[int'(grant_nxt)*M +: M];
                pend      <= req_en[int'(grant_nxt)*M +: M];
                ret_pend  <= req_en[int'(grant_nxt)*M +: M];
                addr_q    <= req_addr[int'(grant_nxt)*M*A +: M*A];
                req_ack_q <= N'(1) << grant_nxt;
                ret_cnt   <= '0;
                for (int m = 0; m < M; m++) slots[m] <= '0;
            end
            if (cmd_fire) pend <= pend & ~cur_bit;
            if (ret_fire) begin
                slots[ret_slot] <= mem_rd_data;
                ret_pend        <= ret_pend & ~ret_bit;
                ret_cnt         <= ret_cnt + MW'(1);
            end
            if (state == S_RESP) begin
                rr_ptr <= (grant_id == IW'(N - 1)) ? '0 : grant_id + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_factor_fetch_arbiter.sv
// Directed bench for factor_fetch_arbiter: per-PE request drivers, an in-order memory model
// with programmable latency and stalls, and a response scoreboard.
module tb_factor_fetch_arbiter;

    localparam int N  = 8;
    localparam int M  = 2;
    localparam int R  = 16;
    localparam int W  = 32;
    localparam int A  = 16;
    localparam int RW = R * W;
    localparam int MW = 2;
    localparam int IW = 3;
    localparam int CW = 4;
    localparam int XW = CW + M + M * RW;

    logic              clk;
    logic              rst;
    logic [N*M-1:0]    req_en;
    logic [N*M*A-1:0]  req_addr;
    logic [N-1:0]      req_ack;
    logic              mem_rd_en;
    logic              mem_rd_ready;
    logic [MW-1:0]     mem_rd_mode;
    logic [A-1:0]      mem_rd_addr;
    logic              mem_rd_valid;
    logic [RW-1:0]     mem_rd_data;
    logic [M-1:0]      resp_en;
    logic [M*RW-1:0]   resp_data;
    logic [CW-1:0]     resp_compute_id;
    logic              proto_err;
    logic [1:0]        dbg_state;
    logic [IW-1:0]     dbg_rr_ptr;

    factor_fetch_arbiter dut (
        .clk(clk), .rst(rst), .req_en(req_en), .req_addr(req_addr), .req_ack(req_ack),
        .mem_rd_en(mem_rd_en), .mem_rd_ready(mem_rd_ready), .mem_rd_mode(mem_rd_mode),
        .mem_rd_addr(mem_rd_addr), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .resp_en(resp_en), .resp_data(resp_data), .resp_compute_id(resp_compute_id),
        .proto_err(proto_err), .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- bench state ----------------
    int n_tests = 0;
    int n_fail  = 0;

    int             pe_total [N];
    int             pe_acks  [N];
    logic [M-1:0]   pe_mask  [N];
    logic [M*A-1:0] pe_addr  [N];
    int             ack_q [$];

    int             mem_lat = 1;
    int             cyc = 0;
    int             mq_mode [$];
    logic [A-1:0]   mq_addr [$];
    int             mq_due  [$];
    int             log_mode [$];
    logic [A-1:0]   log_addr [$];
    int             log_cyc  [$];
    int             stall_req = 0;
    int             stall_done = 0;
    int             stall_cnt = 0;
    int             stall_cycles = 0;
    int             hold_viol = 0;
    logic [MW-1:0]  snap_mode;
    logic [A-1:0]   snap_addr;

    logic [XW-1:0]  exp_q [$];
    int             resp_cnt = 0;
    int             served [N];

    task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] row_fn(input int m, input logic [A-1:0] a);
        logic [RW-1:0] r;
        for (int e = 0; e < R; e++) r[e*W +: W] = {4'(m), 4'(e), 8'hA5, a};
        return r;
    endfunction

    // ---------------- request drivers ----------------
    initial begin
        req_en   = '0;
        req_addr = '0;
        for (int i = 0; i < N; i++) begin
            pe_acks[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (req_ack[i]) begin
                    pe_acks[i]++;
                    ack_q.push_back(i);
                end
                if (pe_acks[i] < pe_total[i]) begin
                    req_en[i*M +: M]     = pe_mask[i];
                    req_addr[i*M*A +: M*A] = pe_addr[i];
                end else begin
                    req_en[i*M +: M] = '0;
                end
            end
        end
    end

    // ---------------- memory model ----------------
    initial begin
        mem_rd_ready = 1'b1;
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            mem_rd_valid = 1'b0;
            mem_rd_data  = '0;
            if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = row_fn(mq_mode.pop_front(), mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            if (stall_done < stall_req && mem_rd_en && stall_cnt == 0) begin
                stall_done++;
                stall_cnt = 5;
                snap_mode = mem_rd_mode;
                snap_addr = mem_rd_addr;
            end
            if (stall_cnt > 0) begin
                mem_rd_ready = 1'b0;
                stall_cnt--;
                stall_cycles++;
                if (!mem_rd_en || mem_rd_mode != snap_mode || mem_rd_addr != snap_addr) hold_viol++;
            end else begin
                mem_rd_ready = 1'b1;
            end
            if (mem_rd_en && mem_rd_ready) begin
                mq_mode.push_back(int'(mem_rd_mode));
                mq_addr.push_back(mem_rd_addr);
                mq_due.push_back(cyc + mem_lat);
                log_mode.push_back(int'(mem_rd_mode));
                log_addr.push_back(mem_rd_addr);
                log_cyc.push_back(cyc);
            end
        end
    end

    // ---------------- response scoreboard ----------------
    initial begin
        logic [XW-1:0] x;
        for (int i = 0; i < N; i++) served[i] = 0;
        forever begin
            @(negedge clk);
            if (resp_en != '0) begin
                resp_cnt++;
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", {resp_compute_id, resp_en}, '0);
                end else begin
                    x = exp_q.pop_front();
                    check("resp_id", resp_compute_id, x[XW-1 -: CW]);
                    check("resp_en", resp_en, x[M*RW +: M]);
                    check("resp_data", resp_data, x[M*RW-1:0]);
                    served[resp_compute_id[IW-1:0]]++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_pe(input int i, input logic [M-1:0] m, input logic [A-1:0] a0,
                          input logic [A-1:0] a1, input int reps);
        pe_mask[i] = m;
        pe_addr[i] = {a1, a0};
        pe_total[i] = pe_total[i] + reps;
    endtask

    task automatic push_exp(input int i);
        logic [M*RW-1:0] d;
        d = '0;
        for (int m = 0; m < M; m++) begin
            if (pe_mask[i][m]) d[m*RW +: RW] = row_fn(m, pe_addr[i][m*A +: A]);
        end
        exp_q.push_back({CW'(i), pe_mask[i], d});
    endtask

    task automatic wait_resps(input string tag, input int target, input int budget);
        int c;
        c = 0;
        while (resp_cnt < target && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        check(tag, resp_cnt >= target, 1'b1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_cmd(input string tag, input int idx, input int mode, input int addr);
        logic [MW+A-1:0] got;
        got = '1;
        if (idx < log_mode.size()) got = {MW'(log_mode[idx]), log_addr[idx]};
        check(tag, got, {MW'(mode), A'(addr)});
    endtask

    task automatic check_ack(input string tag, input int idx, input int id);
        int got;
        got = -1;
        if (idx < ack_q.size()) got = ack_q[idx];
        check(tag, got, id);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lb, ab, base, cw, k;
        int served0 [N];
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            pe_total[i] = 0;
            pe_mask[i]  = '0;
            pe_addr[i]  = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mem_rd_en", mem_rd_en, 1'b0);
        check("rst_req_ack", req_ack, '0);
        check("rst_resp_en", resp_en, '0);
        check("rst_resp_id", resp_compute_id, '0);
        check("rst_proto_err", proto_err, 1'b0);
        check("rst_state", dbg_state, 2'd0);
        check("rst_rr_ptr", dbg_rr_ptr, '0);

        // PEs 0,3,5 together, PE0 asks twice: grants 0,3,5,0
        mem_lat = 2;
        ab = ack_q.size();
        set_pe(0, 2'b01, 16'h0100, 16'h0000, 2);
        set_pe(3, 2'b11, 16'h0301, 16'h0302, 1);
        set_pe(5, 2'b10, 16'h0000, 16'h0502, 1);
        push_exp(0); push_exp(3); push_exp(5); push_exp(0);
        wait_resps("rr_done", resp_cnt + 4, 400);
        check_ack("rr_ack0", ab + 0, 0);
        check_ack("rr_ack1", ab + 1, 3);
        check_ack("rr_ack2", ab + 2, 5);
        check_ack("rr_ack3", ab + 3, 0);
        check("rr_ptr_after", dbg_rr_ptr, 3'd1);
        check("rr_idle", dbg_state, 2'd0);

        // PE2 both modes, latency 3
        mem_lat = 3;
        lb = log_mode.size();
        ab = ack_q.size();
        set_pe(2, 2'b11, 16'h0010, 16'h0020, 1);
        push_exp(2);
        wait_resps("pe2_done", resp_cnt + 1, 200);
        check("pe2_ncmd", log_mode.size() - lb, 2);
        check_cmd("pe2_cmd0", lb, 0, 16'h0010);
        check_cmd("pe2_cmd1", lb + 1, 1, 16'h0020);
        check("pe2_back2back", (log_cyc.size() >= lb + 2) ? log_cyc[lb+1] - log_cyc[lb] : 0, 1);
        check("pe2_nack", ack_q.size() - ab, 1);
        check_ack("pe2_ack", ab, 2);

        // PE7 mode 1 only
        mem_lat = 2;
        lb = log_mode.size();
        ab = ack_q.size();
        set_pe(7, 2'b10, 16'h0000, 16'h03FF, 1);
        push_exp(7);
        wait_resps("pe7_done", resp_cnt + 1, 200);
        check("pe7_ncmd", log_mode.size() - lb, 1);
        check_cmd("pe7_cmd0", lb, 1, 16'h03FF);
        check_ack("pe7_ack", ab, 7);
        check("pe7_rr_wrap", dbg_rr_ptr, 3'd0);

        // PE4 with a 5-cycle memory stall in ISSUE
        lb = log_mode.size();
        base = stall_cycles;
        stall_req++;
        set_pe(4, 2'b11, 16'h4444, 16'h5555, 1);
        push_exp(4);
        wait_resps("stall_done", resp_cnt + 1, 200);
        check("stall_len", stall_cycles - base, 5);
        check("stall_hold", hold_viol, 0);
        check("stall_ncmd", log_mode.size() - lb, 2);
        check_cmd("stall_cmd0", lb, 0, 16'h4444);
        check_cmd("stall_cmd1", lb + 1, 1, 16'h5555);
        check("proto_clean", proto_err, 1'b0);

        // reset while waiting on a slow memory; returns land after release
        mem_lat = 6;
        base = resp_cnt;
        set_pe(6, 2'b11, 16'h0601, 16'h0602, 1);
        cw = 0;
        while (dbg_state != 2'd2 && cw < 100) begin
            @(posedge clk);
            #1;
            cw++;
        end
        check("mid_reach_wait", dbg_state, 2'd2);
        rst = 1'b0;
        #1;
        check("mid_rst_state", dbg_state, 2'd0);
        check("mid_rst_mem_rd_en", mem_rd_en, 1'b0);
        check("mid_rst_resp_en", resp_en, '0);
        check("mid_rst_proto", proto_err, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("stray_proto_err", proto_err, 1'b1);
        check("stray_no_resp", resp_cnt - base, 0);
        check("stray_mem_rd_en", mem_rd_en, 1'b0);
        check("stray_req_ack", req_ack, '0);
        check("stray_rr_ptr", dbg_rr_ptr, '0);
        check("stray_drained", mq_due.size(), 0);

        mem_lat = 2;
        ab = ack_q.size();
        set_pe(1, 2'b01, 16'h1111, 16'h0000, 1);
        push_exp(1);
        wait_resps("pe1_done", resp_cnt + 1, 200);
        check_ack("pe1_ack", ab, 1);
        check("pe1_proto_sticky", proto_err, 1'b1);

        // all PEs continuously, latency 1: three full rounds starting from rr_ptr=2
        mem_lat = 1;
        ab = ack_q.size();
        for (int i = 0; i < N; i++) served0[i] = served[i];
        for (int i = 0; i < N; i++) begin
            set_pe(i, 2'((i % 3) + 1), 16'(i * 256 + 1), 16'(i * 256 + 2), 3);
        end
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < N; j++) push_exp((2 + j) % N);
        end
        wait_resps("all_done", resp_cnt + 3 * N, 3000);
        k = 0;
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < N; j++) begin
                check_ack($sformatf("all_ack%0d", k), ab + k, (2 + j) % N);
                k++;
            end
        end
        for (int i = 0; i < N; i++) check($sformatf("all_served%0d", i), served[i] - served0[i], 3);
        check("all_exp_empty", exp_q.size(), 0);
        check("all_proto_sticky", proto_err, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
